// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between two requesters,
// with a 1-deep registered response buffer and a saturating overflow-event counter.
module alu_share_arbiter #(
    parameter int DW   = 32,
    parameter int OPW  = 4,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [DW-1:0]   req0_a,
    input  logic [DW-1:0]   req0_b,
    input  logic [OPW-1:0]  req0_op,
    input  logic            req0_sel,
    input  logic [4:0]      req0_shamt,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [DW-1:0]   req1_a,
    input  logic [DW-1:0]   req1_b,
    input  logic [OPW-1:0]  req1_op,
    input  logic            req1_sel,
    input  logic [4:0]      req1_shamt,
    output logic [DW-1:0]   alu_a,
    output logic [DW-1:0]   alu_b,
    output logic [OPW-1:0]  alu_op,
    output logic            alu_sel,
    output logic [4:0]      alu_shamt,
    input  logic [DW-1:0]   alu_c,
    input  logic            alu_ovf,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic            resp_id,
    output logic [DW-1:0]   resp_c,
    output logic            resp_ovf,
    output logic [CNTW-1:0] ovf_cnt
);
    logic last_grant;
    logic can_issue;
    logic accept;
    logic grant;

    always_comb begin
        can_issue  = !resp_valid || resp_ready;
        accept     = can_issue && (req0_valid || req1_valid);
        // On contention the port that did not win last time gets the ALU.
        grant      = (req0_valid && req1_valid) ? !last_grant : req1_valid;
        req0_ready = accept && !grant;
        req1_ready = accept && grant;
        alu_a      = !accept ? '0 : grant ? req1_a     : req0_a;
        alu_b      = !accept ? '0 : grant ? req1_b     : req0_b;
        alu_op     = !accept ? '0 : grant ? req1_op    : req0_op;
        alu_sel    = !accept ? '0 : grant ? req1_sel   : req0_sel;
        alu_shamt  = !accept ? '0 : grant ? req1_shamt : req0_shamt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_c     <= '0;
            resp_ovf   <= 1'b0;
            ovf_cnt    <= '0;
            last_grant <= 1'b1;
        end else if (accept) begin
            resp_valid <= 1'b1;
            resp_id    <= grant;
            resp_c     <= alu_c;
            resp_ovf   <= alu_ovf;
            last_grant <= grant;
            if (alu_ovf && ovf_cnt != {CNTW{1'b1}})
                ovf_cnt <= ovf_cnt + 1'b1;
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed bench with a behavioural ALU closing the alu_* loop.
module tb_alu_share_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, req0_sel, req1_sel;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic [4:0]  req0_shamt, req1_shamt;
    logic [31:0] alu_a, alu_b, alu_c;
    logic [3:0]  alu_op;
    logic        alu_sel, alu_ovf;
    logic [4:0]  alu_shamt;
    logic        resp_valid, resp_ready, resp_id, resp_ovf;
    logic [31:0] resp_c;
    logic [7:0]  ovf_cnt;
    int          checks = 0;
    int          failures = 0;

    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND = 4'd2, OR = 4'd3, XOR = 4'd4,
                           SLL = 4'd5, SRL = 4'd6, SRA = 4'd7, SLT = 4'd8;

    always #5 clk = ~clk;

    alu_share_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op), .req0_sel(req0_sel), .req0_shamt(req0_shamt),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_op(req1_op), .req1_sel(req1_sel), .req1_shamt(req1_shamt),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_sel(alu_sel), .alu_shamt(alu_shamt),
        .alu_c(alu_c), .alu_ovf(alu_ovf),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_c(resp_c), .resp_ovf(resp_ovf), .ovf_cnt(ovf_cnt)
    );

    // Shift ops shift B by either the immediate or A[4:0].
    logic [4:0] sh;
    always_comb begin
        sh      = alu_sel ? alu_shamt : alu_a[4:0];
        alu_c   = 32'h0;
        alu_ovf = 1'b0;
        case (alu_op)
            ADD: begin
                alu_c   = alu_a + alu_b;
                alu_ovf = (alu_a[31] == alu_b[31]) && (alu_c[31] != alu_a[31]);
            end
            SUB: begin
                alu_c   = alu_a - alu_b;
                alu_ovf = (alu_a[31] != alu_b[31]) && (alu_c[31] != alu_a[31]);
            end
            AND: alu_c = alu_a & alu_b;
            OR:  alu_c = alu_a | alu_b;
            XOR: alu_c = alu_a ^ alu_b;
            SLL: alu_c = alu_b << sh;
            SRL: alu_c = alu_b >> sh;
            SRA: alu_c = $unsigned($signed(alu_b) >>> sh);
            SLT: alu_c = {31'h0, $signed(alu_a) < $signed(alu_b)};
            default: alu_c = 32'h0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        {req0_valid, req1_valid, req0_sel, req1_sel, resp_ready} = '0;
        {req0_a, req0_b, req1_a, req1_b} = '0;
        {req0_op, req1_op, req0_shamt, req1_shamt} = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_id",    {31'h0, resp_id},    32'h0);
        chk("rst_c",     resp_c,              32'h0);
        chk("rst_ovf",   {31'h0, resp_ovf},   32'h0);
        chk("rst_cnt",   {24'h0, ovf_cnt},    32'h0);

        // Single add on port 0, one-cycle latency.
        req0_valid = 1'b1; req0_op = ADD; req0_a = 32'd5; req0_b = 32'd7; resp_ready = 1'b1;
        settle();
        chk("t1_ready0", {31'h0, req0_ready}, 32'h1);
        chk("t1_ready1", {31'h0, req1_ready}, 32'h0);
        tick();
        req0_valid = 1'b0;
        chk("t1_valid", {31'h0, resp_valid}, 32'h1);
        chk("t1_id",    {31'h0, resp_id},    32'h0);
        chk("t1_c",     resp_c,              32'd12);
        chk("t1_ovf",   {31'h0, resp_ovf},   32'h0);
        tick();
        chk("t1_drain", {31'h0, resp_valid}, 32'h0);
        tick();
        chk("t1_idle_ready_ignored", {31'h0, resp_valid}, 32'h0);

        // Port-1-only op moves last_grant to 1, so port 0 wins the next contention.
        req1_valid = 1'b1; req1_op = SUB; req1_a = 32'd10; req1_b = 32'd3;
        tick();
        req1_valid = 1'b0;
        chk("p1_c",  resp_c,           32'd7);
        chk("p1_id", {31'h0, resp_id}, 32'h1);

        // Both ports every cycle: strict alternation at full rate.
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_op = ADD; req1_op = XOR; req0_b = 32'd100; req1_b = 32'hFF;
        for (int i = 0; i < 6; i++) begin
            req0_a = i; req1_a = 32'h10 + i;
            settle();
            chk($sformatf("t2_ready0_%0d", i), {31'h0, req0_ready}, (i % 2 == 0) ? 32'h1 : 32'h0);
            chk($sformatf("t2_ready1_%0d", i), {31'h0, req1_ready}, (i % 2 == 1) ? 32'h1 : 32'h0);
            tick();
            chk($sformatf("t2_valid_%0d", i), {31'h0, resp_valid}, 32'h1);
            chk($sformatf("t2_id_%0d", i), {31'h0, resp_id}, (i % 2 == 1) ? 32'h1 : 32'h0);
            chk($sformatf("t2_c_%0d", i), resp_c, (i % 2 == 0) ? 32'd100 + i : (32'h10 + i) ^ 32'hFF);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        // Backpressure: full buffer blocks port 1 until the consumer drains.
        req0_valid = 1'b1; req0_op = OR; req0_a = 32'hF0; req0_b = 32'h0F;
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op = AND; req1_a = 32'hFFFF0000; req1_b = 32'h0000FFFF;
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk($sformatf("t3_stall_ready1_%0d", i), {31'h0, req1_ready}, 32'h0);
            chk($sformatf("t3_stall_alu_a_%0d", i), alu_a, 32'h0);
            chk($sformatf("t3_hold_c_%0d", i), resp_c, 32'hFF);
            tick();
        end
        chk("t3_hold_valid", {31'h0, resp_valid}, 32'h1);
        resp_ready = 1'b1;
        settle();
        chk("t3_ready1", {31'h0, req1_ready}, 32'h1);
        tick();
        req1_valid = 1'b0;
        chk("t3_id", {31'h0, resp_id}, 32'h1);
        chk("t3_c",  resp_c,           32'h0);
        chk("t3_cnt_zero", {24'h0, ovf_cnt}, 32'h0);
        tick();

        // Signed overflow and counter saturation at 255.
        req0_valid = 1'b1; req0_op = ADD; req0_a = 32'h7FFFFFFF; req0_b = 32'h1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 0) begin
                chk("t4_ovf", {31'h0, resp_ovf}, 32'h1);
                chk("t4_c",   resp_c,            32'h80000000);
                chk("t4_cnt1", {24'h0, ovf_cnt}, 32'h1);
            end
            if (i == 253) chk("t4_cnt254", {24'h0, ovf_cnt}, 32'd254);
            if (i == 254) chk("t4_cnt255", {24'h0, ovf_cnt}, 32'd255);
        end
        req0_valid = 1'b0;
        chk("t4_cnt_sat", {24'h0, ovf_cnt}, 32'd255);
        tick();

        // Arithmetic shift on port 1 with immediate shamt; idle drive is all zero.
        req1_valid = 1'b1; req1_op = SRA; req1_a = 32'h3; req1_b = 32'h80000000;
        req1_sel = 1'b1; req1_shamt = 5'd4;
        settle();
        chk("t5_alu_drive", {alu_op, alu_sel, alu_shamt}, {22'h0, SRA, 1'b1, 5'd4});
        tick();
        req1_valid = 1'b0;
        chk("t5_c",  resp_c,           32'hF8000000);
        chk("t5_id", {31'h0, resp_id}, 32'h1);
        settle();
        chk("t5_idle_ab", alu_a | alu_b, 32'h0);
        chk("t5_idle_ctl", {22'h0, alu_op, alu_sel, alu_shamt}, 32'h0);
        req0_valid = 1'b1; req0_op = SLL; req0_a = 32'd8; req0_b = 32'd1;
        req0_sel = 1'b0; req0_shamt = 5'd2;
        tick();
        req0_valid = 1'b0;
        chk("t5_sll_reg_amt", resp_c, 32'd256);

        // Reset with a pending response; last_grant was 0, reset restores port-0 priority.
        req0_valid = 1'b1; req0_op = ADD; req0_a = 32'd1; req0_b = 32'd1;
        tick();
        req0_valid = 1'b0; resp_ready = 1'b0;
        chk("t6_pending", {31'h0, resp_valid}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_valid", {31'h0, resp_valid}, 32'h0);
        chk("t6_cnt",   {24'h0, ovf_cnt},    32'h0);
        chk("t6_c",     resp_c,              32'h0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        settle();
        chk("t6_ready0", {31'h0, req0_ready}, 32'h1);
        chk("t6_ready1", {31'h0, req1_ready}, 32'h0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("t6_id", {31'h0, resp_id}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
